// File: rtl/counter_updown_mod_if.sv
// Control/status bundle for counter_updown_mod; the counter sits on the slave modport.
// COUNTER_UPDOWN_OVF_STICKY_EN adds the CLR_OVF/OVF sticky overflow pair.
interface counter_updown_mod_if #(
   parameter int unsigned WIDTH = 4
);
   logic             CE;
   logic             UP;
   logic             LOAD;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] O;
   logic             COUT;
   logic             TC;
`ifdef COUNTER_UPDOWN_OVF_STICKY_EN
   logic             CLR_OVF;
   logic             OVF;
`endif

`ifdef COUNTER_UPDOWN_OVF_STICKY_EN
   modport master (output CE, UP, LOAD, D, CLR_OVF, input O, COUT, TC, OVF);
   modport slave  (input CE, UP, LOAD, D, CLR_OVF, output O, COUT, TC, OVF);
`else
   modport master (output CE, UP, LOAD, D, input O, COUT, TC);
   modport slave  (input CE, UP, LOAD, D, output O, COUT, TC);
`endif
endinterface

// File: rtl/counter_updown_mod.sv
// WIDTH-bit up/down counter, modulus MAX+1, with load, enable, wrap/saturate, COUT and TC.
// Optional sticky overflow flag enabled by defining COUNTER_UPDOWN_OVF_STICKY_EN.
module counter_updown_mod #(
   parameter int unsigned     WIDTH    = 4,
   parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
   parameter longint unsigned INIT     = 64'd0,
   parameter int unsigned     SATURATE = 0
) (
   input  logic CLK,
   input  logic RESET,
   counter_updown_mod_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_V  = MAX[WIDTH-1:0];
   localparam logic [WIDTH-1:0] INIT_V = INIT[WIDTH-1:0];
   localparam bit               SAT    = (SATURATE != 0);

   generate
      if (WIDTH < 1) begin : g_bad_width
         $error("counter_updown_mod: WIDTH must be at least 1");
      end
      if (WIDTH < 64 && MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
         $error("counter_updown_mod: MAX does not fit in WIDTH bits");
      end
      if (INIT > MAX) begin : g_bad_init
         $error("counter_updown_mod: INIT exceeds MAX");
      end
   endgenerate

   logic [WIDTH-1:0] count_q;
   logic             cout_q;
   logic [WIDTH-1:0] count_next;
   logic             cout_next;
   logic             at_max;
   logic             at_zero;

   assign at_max  = (count_q == MAX_V);
   assign at_zero = (count_q == '0);

   // Limits are handled by the mux, so the adder never needs a carry bit.
   always_comb begin
      count_next = count_q;
      cout_next  = 1'b0;
      if (bus.LOAD) begin
         count_next = (bus.D > MAX_V) ? MAX_V : bus.D;
      end else if (bus.CE) begin
         if (bus.UP) begin
            if (at_max) begin
               count_next = SAT ? MAX_V : '0;
               cout_next  = 1'b1;
            end else begin
               count_next = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end
         end else begin
            if (at_zero) begin
               count_next = SAT ? '0 : MAX_V;
               cout_next  = 1'b1;
            end else begin
               count_next = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count_q <= INIT_V;
         cout_q  <= 1'b0;
      end else begin
         count_q <= count_next;
         cout_q  <= cout_next;
      end
   end

   assign bus.O    = count_q;
   assign bus.COUT = cout_q;
   assign bus.TC   = bus.CE & ~bus.LOAD & ~RESET & (bus.UP ? at_max : at_zero);

`ifdef COUNTER_UPDOWN_OVF_STICKY_EN
   logic ovf_q;

   // A limit event in the same cycle as a clear request keeps the flag set.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ovf_q <= 1'b0;
      end else if (cout_next) begin
         ovf_q <= 1'b1;
      end else if (bus.CLR_OVF) begin
         ovf_q <= 1'b0;
      end
   end

   assign bus.OVF = ovf_q;
`endif

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: a wrapping MAX=9 instance and a saturating MAX=9, INIT=3 instance.
// Expected O/COUT/OVF go through a scoreboard queue; TC is checked combinationally before each edge.
module tb_counter_updown_mod;

   logic CLK = 1'b0;
   logic RESET_W = 1'b0;
   logic RESET_S = 1'b0;

   always #5 CLK = ~CLK;

   counter_updown_mod_if #(.WIDTH(4)) bw ();
   counter_updown_mod_if #(.WIDTH(4)) bs ();

   counter_updown_mod #(.WIDTH(4), .MAX(9), .INIT(0), .SATURATE(0)) dut_wrap (
      .CLK   (CLK),
      .RESET (RESET_W),
      .bus   (bw.slave)
   );

   counter_updown_mod #(.WIDTH(4), .MAX(9), .INIT(3), .SATURATE(1)) dut_sat (
      .CLK   (CLK),
      .RESET (RESET_S),
      .bus   (bs.slave)
   );

   typedef struct {
      string      tag;
      int         sel;
      logic [3:0] o;
      logic       cout;
      logic       ovf;
      logic       chk_ovf;
   } exp_t;

   exp_t sbQueue[$];
   int   total = 0;
   int   bad   = 0;
   logic expOvfNext = 1'b0;
   logic ovfCheckEn = 1'b0;
   logic clrOvfReq  = 1'b0;

   task automatic checkValue(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sbQueue.size() == 0) begin
         total++;
         bad++;
         $error("[TB] FAIL scoreboard observed=empty expected=entry");
      end else begin
         e = sbQueue.pop_front();
         if (e.sel == 0) begin
            checkValue({e.tag, ".o"}, bw.O, e.o);
            checkValue({e.tag, ".cout"}, {3'b0, bw.COUT}, {3'b0, e.cout});
`ifdef COUNTER_UPDOWN_OVF_STICKY_EN
            if (e.chk_ovf) checkValue({e.tag, ".ovf"}, {3'b0, bw.OVF}, {3'b0, e.ovf});
`endif
         end else begin
            checkValue({e.tag, ".o"}, bs.O, e.o);
            checkValue({e.tag, ".cout"}, {3'b0, bs.COUT}, {3'b0, e.cout});
         end
      end
   endtask

   // Drive one cycle on the selected instance, idle the other, then check both TC and the registered result.
   task automatic applyStimulus(input string tag, input int sel, input logic rst, input logic ld,
                                input logic ce, input logic up, input logic [3:0] d,
                                input logic [3:0] expO, input logic expCout, input logic expTc);
      exp_t e;
      @(negedge CLK);
      if (sel == 0) begin
         RESET_W = rst; bw.LOAD = ld; bw.CE = ce; bw.UP = up; bw.D = d;
         RESET_S = 1'b0; bs.LOAD = 1'b0; bs.CE = 1'b0;
      end else begin
         RESET_S = rst; bs.LOAD = ld; bs.CE = ce; bs.UP = up; bs.D = d;
         RESET_W = 1'b0; bw.LOAD = 1'b0; bw.CE = 1'b0;
      end
`ifdef COUNTER_UPDOWN_OVF_STICKY_EN
      bw.CLR_OVF = (sel == 0) ? clrOvfReq : 1'b0;
      bs.CLR_OVF = 1'b0;
`endif
      e.tag = tag; e.sel = sel; e.o = expO; e.cout = expCout;
      e.ovf = expOvfNext; e.chk_ovf = ovfCheckEn;
      sbQueue.push_back(e);
      #1;
      checkValue({tag, ".tc"}, {3'b0, (sel == 0) ? bw.TC : bs.TC}, {3'b0, expTc});
      @(posedge CLK);
      #1;
      checkOutput();
   endtask

   initial begin
      bw.CE = 1'b0; bw.UP = 1'b0; bw.LOAD = 1'b0; bw.D = 4'd0;
      bs.CE = 1'b0; bs.UP = 1'b0; bs.LOAD = 1'b0; bs.D = 4'd0;
`ifdef COUNTER_UPDOWN_OVF_STICKY_EN
      bw.CLR_OVF = 1'b0; bs.CLR_OVF = 1'b0;
`endif

      // Reset then count up through the wrap at 9
      applyStimulus("w.reset", 0, 1, 0, 1, 1, 4'd0, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++)
         applyStimulus("w.up", 0, 0, 0, 1, 1, 4'd0, 4'((i + 1) % 10), (i % 10) == 9, (i % 10) == 9);

      // Down-count wraps from 0 to MAX
      applyStimulus("w.reset2", 0, 1, 0, 0, 0, 4'd0, 4'd0, 1'b0, 1'b0);
      applyStimulus("w.hold0", 0, 0, 0, 0, 0, 4'd0, 4'd0, 1'b0, 1'b0);
      applyStimulus("w.dn0", 0, 0, 0, 1, 0, 4'd0, 4'd9, 1'b1, 1'b1);
      applyStimulus("w.dn1", 0, 0, 0, 1, 0, 4'd0, 4'd8, 1'b0, 1'b0);
      applyStimulus("w.dn2", 0, 0, 0, 1, 0, 4'd0, 4'd7, 1'b0, 1'b0);

      // Load clamps and load beats count enable
      applyStimulus("w.ld13", 0, 0, 1, 0, 1, 4'd13, 4'd9, 1'b0, 1'b0);
      applyStimulus("w.ldce", 0, 0, 1, 1, 1, 4'd4, 4'd4, 1'b0, 1'b0);

      // Enable gating from 5, and TC masked by CE=0 at MAX
      applyStimulus("w.ld5", 0, 0, 1, 0, 1, 4'd5, 4'd5, 1'b0, 1'b0);
      applyStimulus("w.ce1a", 0, 0, 0, 1, 1, 4'd0, 4'd6, 1'b0, 1'b0);
      applyStimulus("w.ce0", 0, 0, 0, 0, 1, 4'd0, 4'd6, 1'b0, 1'b0);
      applyStimulus("w.ce1b", 0, 0, 0, 1, 1, 4'd0, 4'd7, 1'b0, 1'b0);
      applyStimulus("w.ld9", 0, 0, 1, 0, 1, 4'd9, 4'd9, 1'b0, 1'b0);
      applyStimulus("w.max.ce0", 0, 0, 0, 0, 1, 4'd0, 4'd9, 1'b0, 1'b0);
      applyStimulus("w.max.dn", 0, 0, 0, 1, 0, 4'd0, 4'd8, 1'b0, 1'b0);
      applyStimulus("w.max.up", 0, 0, 0, 1, 1, 4'd0, 4'd9, 1'b0, 1'b0);

      // Reset on the wrap cycle discards the pending carry
      applyStimulus("w.rstwrap", 0, 1, 0, 1, 1, 4'd0, 4'd0, 1'b0, 1'b0);

      // Saturating instance: reset with load goes to INIT, then clamp at both ends
      applyStimulus("s.rstld", 1, 1, 1, 0, 1, 4'd7, 4'd3, 1'b0, 1'b0);
      applyStimulus("s.ld8", 1, 0, 1, 0, 1, 4'd8, 4'd8, 1'b0, 1'b0);
      applyStimulus("s.up0", 1, 0, 0, 1, 1, 4'd0, 4'd9, 1'b0, 1'b0);
      applyStimulus("s.up1", 1, 0, 0, 1, 1, 4'd0, 4'd9, 1'b1, 1'b1);
      applyStimulus("s.up2", 1, 0, 0, 1, 1, 4'd0, 4'd9, 1'b1, 1'b1);
      applyStimulus("s.ld1", 1, 0, 1, 0, 0, 4'd1, 4'd1, 1'b0, 1'b0);
      applyStimulus("s.dn0", 1, 0, 0, 1, 0, 4'd0, 4'd0, 1'b0, 1'b0);
      applyStimulus("s.dn1", 1, 0, 0, 1, 0, 4'd0, 4'd0, 1'b1, 1'b1);
      applyStimulus("s.dn2", 1, 0, 0, 1, 0, 4'd0, 4'd0, 1'b1, 1'b1);

`ifdef COUNTER_UPDOWN_OVF_STICKY_EN
      // Sticky overflow: set on wrap, hold, clear, and set winning over clear
      ovfCheckEn = 1'b1;
      expOvfNext = 1'b0;
      applyStimulus("o.reset", 0, 1, 0, 0, 1, 4'd0, 4'd0, 1'b0, 1'b0);
      applyStimulus("o.ld9", 0, 0, 1, 0, 1, 4'd9, 4'd9, 1'b0, 1'b0);
      expOvfNext = 1'b1;
      applyStimulus("o.wrap", 0, 0, 0, 1, 1, 4'd0, 4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++)
         applyStimulus("o.hold", 0, 0, 0, 0, 1, 4'd0, 4'd0, 1'b0, 1'b0);
      clrOvfReq  = 1'b1;
      expOvfNext = 1'b0;
      applyStimulus("o.clr", 0, 0, 0, 0, 1, 4'd0, 4'd0, 1'b0, 1'b0);
      clrOvfReq  = 1'b0;
      applyStimulus("o.ld9b", 0, 0, 1, 0, 1, 4'd9, 4'd9, 1'b0, 1'b0);
      clrOvfReq  = 1'b1;
      expOvfNext = 1'b1;
      applyStimulus("o.clrwrap", 0, 0, 0, 1, 1, 4'd0, 4'd0, 1'b1, 1'b1);
      clrOvfReq  = 1'b0;
      ovfCheckEn = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised successor to the fixed 4-bit free-running counter: WIDTH-bit synchronous up/down counter with programmable modulus, clock enable, parallel load and wrap-or-saturate mode.
- Used as the generic counting primitive under prescalers, timers and address generators.
- Provides a registered carry/borrow pulse (COUT) and a combinational terminal-count lookahead (TC) so instances cascade without extra logic.

Parameters:
- WIDTH, 4, counter width in bits; must be >= 1.
- MAX, 2**WIDTH-1, terminal value; count range is 0..MAX; must be <= 2**WIDTH-1.
- INIT, 0, value loaded on reset; must be <= MAX.
- SATURATE, 0, 0 = wrap at range limits; 1 = clamp at range limits.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- CE  input  1  count enable.
- UP  input  1  direction: 1 = increment, 0 = decrement; sampled only when counting.
- LOAD  input  1  parallel load strobe.
- D  input  WIDTH  parallel load value.
- O  output  WIDTH  current count, registered.
- COUT  output  1  registered carry/borrow pulse.
- TC  output  1  combinational terminal-count lookahead.

Interface decision: one clock, CLK; reset is RESET, synchronous and active-high.

Behaviour:
- Priority at each rising CLK edge: RESET > LOAD > CE > hold.
- RESET=1: O <= INIT, COUT <= 0. OVF <= 0 when the optional feature is compiled in.
- LOAD=1, RESET=0: O <= min(D, MAX); COUT <= 0. CE and UP are ignored that cycle.
- CE=1, UP=1, O<MAX: O <= O+1; COUT <= 0.
- CE=1, UP=1, O==MAX:
  - SATURATE=0: O <= 0, COUT <= 1.
  - SATURATE=1: O stays MAX, COUT <= 1 (pulse repeats each cycle the increment is attempted).
- CE=1, UP=0, O>0: O <= O-1; COUT <= 0.
- CE=1, UP=0, O==0:
  - SATURATE=0: O <= MAX, COUT <= 1.
  - SATURATE=1: O stays 0, COUT <= 1.
- CE=0, no LOAD/RESET: O holds; COUT <= 0.
- COUT is high for exactly one cycle per wrap/limit event: the cycle in which O shows the post-event value.
- TC = CE & ~LOAD & ~RESET & (UP ? O==MAX : O==0). TC is combinational, with zero latency.
- Arithmetic is modulo MAX+1, not 2**WIDTH. Internal compare and increment are WIDTH bits; the next-state mux handles the limits, so no WIDTH+1 adder is required.
- Direction change takes effect the same cycle UP changes; there is no pipeline.
- Reset mid-count discards the count and any pending COUT.
- A D value above MAX is clamped, never stored.
- Parameter violations (MAX > 2**WIDTH-1, INIT > MAX, WIDTH < 1) must cause an elaboration-time error via generate-time check.

Optional Feature:
- Macro: COUNTER_UPDOWN_OVF_STICKY_EN.
- Defined: adds input CLR_OVF (1 bit) and output OVF (1 bit, registered).
  - OVF <= 1 on any cycle COUT would be set.
  - OVF holds until RESET or CLR_OVF=1 clears it to 0.
  - If CLR_OVF and a COUT event occur in the same cycle, set wins (OVF=1).
  - Reset value of OVF is 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
1. WIDTH=4, MAX=9, INIT=0, SATURATE=0; RESET 1 cycle, then CE=1, UP=1 for 12 cycles -> O = 1..9, 0, 1, 2. COUT=1 only in the cycle O=0 after 9. TC=1 only while O=9.
2. Same config, hold at O=0, then CE=1, UP=0 for 3 cycles -> O = 9, 8, 7. COUT=1 in the cycle O=9.
3. SATURATE=1, MAX=9: count up from 8 for 3 cycles -> O = 9, 9, 9; COUT = 0, 1, 1. Count down from 1 for 3 cycles -> O = 0, 0, 0; COUT = 0, 1, 1.
4. LOAD=1 with D=13, MAX=9 -> O=9, COUT=0. LOAD=1 and CE=1 together with D=4 -> O=4, no increment. RESET=1 with LOAD=1 and INIT=3 -> O=3.
5. CE toggled 1,0,1 with UP=1 from O=5 -> O = 6, 6, 7. COUT stays 0 throughout. TC=0 whenever CE=0, even at O=MAX.
6. With COUNTER_UPDOWN_OVF_STICKY_EN defined: wrap once -> OVF=1 persists for 5 cycles. CLR_OVF pulse -> OVF=0. CLR_OVF asserted in the same cycle as a wrap -> OVF=1.
